// File: rtl/mrd_pkg.sv
// Shared constants, types and helpers for the mixed-radix FFT datapath.
// The twiddle constant is computed at elaboration time from its width.
package mrd_pkg;
   localparam int MRD_LANES = 5;
   localparam int MRD_WEXP  = 4;

   typedef logic [MRD_WEXP-1:0] mrd_exp_t;

   // round(0.8660254 * 2^(wCoef-1)), evaluated in fixed point to stay synthesizable
   function automatic int coef_sqrt3_2(input int wCoef);
      longint scaled;
      scaled = 64'sd8660254 * (64'sd1 <<< (wCoef - 1));
      return int'((scaled + 64'sd5000000) / 64'sd10000000);
   endfunction
endpackage

// File: rtl/mrd_rdx3_v3_if.sv
// Shared 5-lane sample bus between FFT stages, with block exponent side-band.
interface mrd_rdx3_v3_if #(
   parameter int wData = 18,
   parameter int wExp  = 4
) ();
   import mrd_pkg::*;

   logic                    in_val;
   logic                    inv;
   logic signed [wData-1:0] din_real  [0:MRD_LANES-1];
   logic signed [wData-1:0] din_imag  [0:MRD_LANES-1];
   logic [1:0]              margin_in;
   logic [wExp-1:0]         exp_in;
   logic                    out_val;
   logic signed [wData-1:0] dout_real [0:MRD_LANES-1];
   logic signed [wData-1:0] dout_imag [0:MRD_LANES-1];
   logic [wExp-1:0]         exp_out;
   logic                    exp_ovf;

   modport slave (
      input  in_val, inv, din_real, din_imag, margin_in, exp_in,
      output out_val, dout_real, dout_imag, exp_out, exp_ovf
   );

   modport master (
      output in_val, inv, din_real, din_imag, margin_in, exp_in,
      input  out_val, dout_real, dout_imag, exp_out, exp_ovf
   );
endinterface

// File: rtl/mrd_bfp_scale.sv
// Block-floating-point scaler: round-half-up arithmetic right shift of one value
// plus exponent increment with saturation at the top of the exponent range.
module mrd_bfp_scale #(
   parameter int wIn   = 21,
   parameter int wData = 18,
   parameter int wExp  = 4
) (
   input  logic signed [wIn-1:0]   val,
   input  logic [1:0]              shift,
   input  logic [wExp-1:0]         exp_in,
   output logic signed [wData-1:0] res,
   output logic [wExp-1:0]         exp_out,
   output logic                    ovf
);
   logic signed [wIn:0] rnd;
   logic [wExp:0]       esum;

   always_comb begin
      rnd = '0;
      case (shift)
         2'd1:    rnd = (wIn+1)'(1);
         2'd2:    rnd = (wIn+1)'(2);
         default: rnd = '0;
      endcase
   end

   // one guard bit so the rounding add cannot wrap before the shift
   assign res = wData'(($signed({val[wIn-1], val}) + rnd) >>> shift);

   assign esum    = {1'b0, exp_in} + {{(wExp-1){1'b0}}, shift};
   assign ovf     = esum[wExp];
   assign exp_out = esum[wExp] ? {wExp{1'b1}} : esum[wExp-1:0];
endmodule

// File: rtl/mrd_rdx3_v3.sv
// Radix-3 DFT butterfly, forward/inverse per sample, four-stage pipeline with
// block-floating-point output scaling. Lanes 3..4 of the shared bus are unused.
module mrd_rdx3_v3
   import mrd_pkg::*;
#(
   parameter int wData   = 18,
   parameter int wCoef   = 18,
   parameter int wExp    = 4,
   parameter int LATENCY = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   mrd_rdx3_v3_if.slave  bus
);
   localparam int W2 = wData + 2;
   localparam int W3 = wData + 3;
   localparam int WP = W2 + wCoef;
   localparam logic signed [wCoef-1:0] COEF = wCoef'(coef_sqrt3_2(wCoef));

   function automatic logic signed [W2-1:0] mul_c(input logic signed [W2-1:0] d);
      return W2'((WP'(d) * WP'(COEF) + (WP'(1) <<< (wCoef - 2))) >>> (wCoef - 1));
   endfunction

   logic [LATENCY-1:0] vpipe;

   logic signed [W2-1:0] s1_x0r, s1_x0i, s1_sr, s1_si, s1_dr, s1_di;
   logic                 s1_inv, s2_inv;
   logic [1:0]           s1_sh, s2_sh, s3_sh;
   logic [wExp-1:0]      s1_exp, s2_exp, s3_exp;

   logic signed [W2-1:0] s2_x0r, s2_x0i, s2_ar, s2_ai, s2_cdr, s2_cdi;

   logic signed [W3-1:0] x1r_c, x1i_c, x2r_c, x2i_c;
   logic signed [W3-1:0] s3_re [0:2];
   logic signed [W3-1:0] s3_im [0:2];

   logic signed [wData-1:0] sc_re [0:2];
   logic signed [wData-1:0] sc_im [0:2];
   logic [wExp-1:0]         exp_l [0:5];
   logic                    ovf_l [0:5];
   logic [wExp-1:0]         exp_c;
   logic                    ovf_c;

   logic signed [wData-1:0] s4_re [0:2];
   logic signed [wData-1:0] s4_im [0:2];
   logic [wExp-1:0]         s4_exp;
   logic                    s4_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vpipe <= '0;
      else        vpipe <= {vpipe[LATENCY-2:0], bus.in_val};
   end

   // st1: capture, form sum and difference of x1 and x2
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_x0r <= '0; s1_x0i <= '0; s1_sr <= '0; s1_si <= '0; s1_dr <= '0; s1_di <= '0;
         s1_inv <= 1'b0; s1_sh <= '0; s1_exp <= '0;
      end else if (bus.in_val) begin
         s1_x0r <= W2'(bus.din_real[0]);
         s1_x0i <= W2'(bus.din_imag[0]);
         s1_sr  <= W2'(bus.din_real[1]) + W2'(bus.din_real[2]);
         s1_si  <= W2'(bus.din_imag[1]) + W2'(bus.din_imag[2]);
         s1_dr  <= W2'(bus.din_real[1]) - W2'(bus.din_real[2]);
         s1_di  <= W2'(bus.din_imag[1]) - W2'(bus.din_imag[2]);
         s1_inv <= bus.inv;
         s1_sh  <= (bus.margin_in >= 2'd2) ? 2'd0 : 2'd2 - bus.margin_in;
         s1_exp <= bus.exp_in;
      end
   end

   // st2: twiddle products and the shared term A = x0 - s/2
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_x0r <= '0; s2_x0i <= '0; s2_ar <= '0; s2_ai <= '0; s2_cdr <= '0; s2_cdi <= '0;
         s2_inv <= 1'b0; s2_sh <= '0; s2_exp <= '0;
      end else if (vpipe[0]) begin
         s2_x0r <= s1_x0r + s1_sr;
         s2_x0i <= s1_x0i + s1_si;
         s2_ar  <= s1_x0r - (s1_sr >>> 1);
         s2_ai  <= s1_x0i - (s1_si >>> 1);
         s2_cdr <= mul_c(s1_dr);
         s2_cdi <= mul_c(s1_di);
         s2_inv <= s1_inv;
         s2_sh  <= s1_sh;
         s2_exp <= s1_exp;
      end
   end

   always_comb begin
      x1r_c = W3'(s2_ar) + W3'(s2_cdi);
      x1i_c = W3'(s2_ai) - W3'(s2_cdr);
      x2r_c = W3'(s2_ar) - W3'(s2_cdi);
      x2i_c = W3'(s2_ai) + W3'(s2_cdr);
   end

   // st3: final sums; the inverse transform just exchanges X1 and X2
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 3; k++) begin
            s3_re[k] <= '0;
            s3_im[k] <= '0;
         end
         s3_sh  <= '0;
         s3_exp <= '0;
      end else if (vpipe[1]) begin
         s3_re[0] <= W3'(s2_x0r);
         s3_im[0] <= W3'(s2_x0i);
         s3_re[1] <= s2_inv ? x2r_c : x1r_c;
         s3_im[1] <= s2_inv ? x2i_c : x1i_c;
         s3_re[2] <= s2_inv ? x1r_c : x2r_c;
         s3_im[2] <= s2_inv ? x1i_c : x2i_c;
         s3_sh    <= s2_sh;
         s3_exp   <= s2_exp;
      end
   end

   for (genvar k = 0; k < 3; k++) begin : g_scale
      mrd_bfp_scale #(.wIn(W3), .wData(wData), .wExp(wExp)) u_re (
         .val(s3_re[k]), .shift(s3_sh), .exp_in(s3_exp),
         .res(sc_re[k]), .exp_out(exp_l[2*k]), .ovf(ovf_l[2*k])
      );
      mrd_bfp_scale #(.wIn(W3), .wData(wData), .wExp(wExp)) u_im (
         .val(s3_im[k]), .shift(s3_sh), .exp_in(s3_exp),
         .res(sc_im[k]), .exp_out(exp_l[2*k+1]), .ovf(ovf_l[2*k+1])
      );
   end

   // every lane sees the same shift and exponent, so merging is an identity
   always_comb begin
      exp_c = '0;
      ovf_c = 1'b0;
      for (int i = 0; i < 6; i++) begin
         exp_c = exp_c | exp_l[i];
         ovf_c = ovf_c | ovf_l[i];
      end
   end

   // st4: scaled outputs; overflow flag lives only for its own output beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 3; k++) begin
            s4_re[k] <= '0;
            s4_im[k] <= '0;
         end
         s4_exp <= '0;
         s4_ovf <= 1'b0;
      end else begin
         s4_ovf <= vpipe[2] & ovf_c;
         if (vpipe[2]) begin
            for (int k = 0; k < 3; k++) begin
               s4_re[k] <= sc_re[k];
               s4_im[k] <= sc_im[k];
            end
            s4_exp <= exp_c;
         end
      end
   end

   for (genvar k = 0; k < MRD_LANES; k++) begin : g_out
      if (k < 3) begin : g_used
         assign bus.dout_real[k] = s4_re[k];
         assign bus.dout_imag[k] = s4_im[k];
      end else begin : g_idle
         assign bus.dout_real[k] = '0;
         assign bus.dout_imag[k] = '0;
      end
   end

   assign bus.out_val = vpipe[LATENCY-1];
   assign bus.exp_out = s4_exp;
   assign bus.exp_ovf = s4_ovf;
endmodule

// File: tb/tb_mrd_rdx3_v3.sv
// Bench for the radix-3 butterfly: directed vector table, random stream against
// an arithmetic reference model, and a mid-stream reset flush.
module tb_mrd_rdx3_v3;
   import mrd_pkg::*;

   typedef struct packed {
      logic [2:0][31:0] xr;
      logic [2:0][31:0] xi;
      logic             inv;
      logic [1:0]       margin;
      logic [3:0]       expi;
      logic [2:0][31:0] er;
      logic [2:0][31:0] ei;
      mrd_exp_t         eexp;
      logic             eovf;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mrd_rdx3_v3_if #(.wData(18), .wExp(4)) bus ();

   mrd_rdx3_v3 #(.wData(18), .wCoef(18), .wExp(4), .LATENCY(4)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   n_out = 0;
   int   first_c = 0;
   int   last_c = 0;
   bit   mon_en = 1'b0;
   vec_t exp_q[$];
   vec_t mv;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint want);
      n_chk++;
      if (act != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, act, want);
      end
   endtask

   function automatic longint fdiv(input longint a, input int k);
      longint p;
      longint q;
      p = 64'sd1 <<< k;
      q = a / p;
      if ((a % p) != 0 && a < 0) q = q - 1;
      return q;
   endfunction

   function automatic longint wrap18(input longint a);
      longint m;
      m = a & 64'h3FFFF;
      if (m >= 64'h20000) m = m - 64'h40000;
      return m;
   endfunction

   // 3-point DFT from its definition with C = round(sqrt(3)/2 * 2^17)
   function automatic vec_t model(input vec_t v);
      longint xr[3], xi[3], yr[3], yi[3];
      longint sr, si, dr, di, cdr, cdi, ar, ai, rnd;
      int sh, es;
      for (int k = 0; k < 3; k++) begin
         xr[k] = longint'($signed(v.xr[k]));
         xi[k] = longint'($signed(v.xi[k]));
      end
      sr = xr[1] + xr[2]; si = xi[1] + xi[2];
      dr = xr[1] - xr[2]; di = xi[1] - xi[2];
      cdr = fdiv(dr * 113512 + 65536, 17);
      cdi = fdiv(di * 113512 + 65536, 17);
      ar = xr[0] - fdiv(sr, 1);
      ai = xi[0] - fdiv(si, 1);
      yr[0] = xr[0] + sr; yi[0] = xi[0] + si;
      if (!v.inv) begin
         yr[1] = ar + cdi; yi[1] = ai - cdr; yr[2] = ar - cdi; yi[2] = ai + cdr;
      end else begin
         yr[2] = ar + cdi; yi[2] = ai - cdr; yr[1] = ar - cdi; yi[1] = ai + cdr;
      end
      sh  = (v.margin >= 2) ? 0 : 2 - int'(v.margin);
      rnd = (sh == 0) ? 64'sd0 : (64'sd1 <<< (sh - 1));
      for (int k = 0; k < 3; k++) begin
         v.er[k] = 32'(wrap18(fdiv(yr[k] + rnd, sh)));
         v.ei[k] = 32'(wrap18(fdiv(yi[k] + rnd, sh)));
      end
      es = int'(v.expi) + sh;
      if (es > 15) begin
         v.eexp = 4'hF; v.eovf = 1'b1;
      end else begin
         v.eexp = 4'(es); v.eovf = 1'b0;
      end
      return v;
   endfunction

   function automatic vec_t mk(input int x0r, x0i, x1r, x1i, x2r, x2i,
                               input bit inv, input int margin, expi,
                               input int e0r, e0i, e1r, e1i, e2r, e2i,
                               input int eexp, input bit eovf);
      vec_t v;
      v = '0;
      v.xr[0] = x0r; v.xi[0] = x0i; v.xr[1] = x1r; v.xi[1] = x1i; v.xr[2] = x2r; v.xi[2] = x2i;
      v.inv = inv; v.margin = 2'(margin); v.expi = 4'(expi);
      v.er[0] = e0r; v.ei[0] = e0i; v.er[1] = e1r; v.ei[1] = e1i; v.er[2] = e2r; v.ei[2] = e2i;
      v.eexp = 4'(eexp); v.eovf = eovf;
      return v;
   endfunction

   function automatic vec_t rand_vec();
      vec_t v;
      int m, lim;
      v   = '0;
      m   = int'($urandom_range(3, 0));
      lim = 1 << (17 - m);
      for (int k = 0; k < 3; k++) begin
         v.xr[k] = int'($urandom_range(2 * lim - 1, 0)) - lim;
         v.xi[k] = int'($urandom_range(2 * lim - 1, 0)) - lim;
      end
      v.inv    = 1'($urandom_range(1, 0));
      v.margin = 2'(m);
      v.expi   = 4'($urandom_range(15, 0));
      return model(v);
   endfunction

   task automatic drive(input vec_t v);
      for (int k = 0; k < 3; k++) begin
         bus.din_real[k] = v.xr[k][17:0];
         bus.din_imag[k] = v.xi[k][17:0];
      end
      for (int k = 3; k < 5; k++) begin
         bus.din_real[k] = 18'($urandom);
         bus.din_imag[k] = 18'($urandom);
      end
      bus.inv       = v.inv;
      bus.margin_in = v.margin;
      bus.exp_in    = v.expi;
   endtask

   task automatic scramble();
      for (int k = 0; k < 5; k++) begin
         bus.din_real[k] = 18'($urandom);
         bus.din_imag[k] = 18'($urandom);
      end
      bus.inv = 1'($urandom); bus.margin_in = 2'($urandom); bus.exp_in = 4'($urandom);
   endtask

   task automatic check_out(input vec_t v, input string tag);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s re%0d", tag, k), longint'(bus.dout_real[k]), longint'($signed(v.er[k])));
         chk($sformatf("%s im%0d", tag, k), longint'(bus.dout_imag[k]), longint'($signed(v.ei[k])));
      end
      for (int k = 3; k < 5; k++) begin
         chk($sformatf("%s re%0d", tag, k), longint'(bus.dout_real[k]), 0);
         chk($sformatf("%s im%0d", tag, k), longint'(bus.dout_imag[k]), 0);
      end
      chk({tag, " exp_out"}, longint'(bus.exp_out), longint'(v.eexp));
      chk({tag, " exp_ovf"}, longint'(bus.exp_ovf), longint'(v.eovf));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, " out_val"}, longint'(bus.out_val), 0);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("%s re%0d", tag, k), longint'(bus.dout_real[k]), 0);
         chk($sformatf("%s im%0d", tag, k), longint'(bus.dout_imag[k]), 0);
      end
      chk({tag, " exp_out"}, longint'(bus.exp_out), 0);
      chk({tag, " exp_ovf"}, longint'(bus.exp_ovf), 0);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      lat = 0;
      @(posedge clk); #1;
      drive(v);
      bus.in_val = 1'b1;
      for (int c = 1; c <= 10 && lat == 0; c++) begin
         @(posedge clk); @(negedge clk);
         if (c == 1) begin
            bus.in_val = 1'b0;
            scramble();
         end
         if (bus.out_val) lat = c;
      end
      chk({tag, " latency"}, lat, 4);
      check_out(v, tag);
      @(negedge clk);
      chk({tag, " idle out_val"}, longint'(bus.out_val), 0);
      chk({tag, " idle exp_ovf"}, longint'(bus.exp_ovf), 0);
      chk({tag, " hold re0"}, longint'(bus.dout_real[0]), longint'($signed(v.er[0])));
   endtask

   always @(negedge clk) begin
      if (mon_en && bus.out_val) begin
         if (exp_q.size() == 0) begin
            chk("stream unexpected out_val", 1, 0);
         end else begin
            mv = exp_q.pop_front();
            check_out(mv, $sformatf("stream#%0d", n_out));
            if (n_out == 0) first_c = cyc;
            last_c = cyc;
            n_out++;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, n_out=%0d", n_out);
      $fatal(1, "watchdog");
   end

   vec_t  tab [7];
   string nm  [7];

   initial begin
      int seen;
      tab[0] = mk(4000, 0, 0, 0, 0, 0,           0, 2, 3,  4000, 0, 4000, 0, 4000, 0,  3, 0);
      tab[1] = mk(1000, 0, 1000, 0, 1000, 0,     0, 2, 0,  3000, 0, 0, 0, 0, 0,        0, 0);
      tab[2] = mk(0, 0, 1000, 0, 0, 0,           0, 2, 7,  1000, 0, -500, -866, -500, 866, 7, 0);
      tab[3] = mk(0, 0, 1000, 0, 0, 0,           1, 2, 7,  1000, 0, -500, 866, -500, -866, 7, 0);
      tab[4] = mk(131071, 0, 131071, 0, 131071, 0, 0, 0, 15, 98303, 0, 0, 0, 0, 0,    15, 1);
      tab[5] = mk(131071, 0, 131071, 0, 131071, 0, 0, 0, 5,  98303, 0, 0, 0, 0, 0,    7, 0);
      tab[6] = mk(1001, -3, 0, 0, 0, 0,          0, 1, 14, 501, -1, 501, -1, 501, -1,  15, 0);
      nm = '{"impulse", "dc", "twiddle_fwd", "twiddle_inv", "fullscale_e15", "fullscale_e5", "margin1_round"};

      bus.in_val = 1'b0;
      scramble();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) run_vec(tab[i], nm[i]);

      mon_en = 1'b1;
      for (int i = 0; i < 32; i++) begin
         @(posedge clk); #1;
         mv = rand_vec();
         drive(mv);
         bus.in_val = 1'b1;
         exp_q.push_back(mv);
      end
      @(posedge clk); #1;
      bus.in_val = 1'b0;
      for (int c = 0; c < 20 && n_out < 32; c++) @(posedge clk);
      @(negedge clk);
      chk("stream count", n_out, 32);
      chk("stream contiguous span", last_c - first_c + 1, 32);
      chk("stream leftover", exp_q.size(), 0);
      mon_en = 1'b0;

      // burst interrupted by reset two cycles in
      @(posedge clk); #1;
      mv = rand_vec(); drive(mv); bus.in_val = 1'b1;
      @(posedge clk); #1;
      mv = rand_vec(); drive(mv);
      @(posedge clk); #1;
      rst_n = 1'b0;
      bus.in_val = 1'b0;
      #2;
      check_zero("in reset");
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus.out_val) seen++;
      end
      chk("post-reset out_val beats", seen, 0);
      check_zero("post reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
